// File: rtl/l2_mem_responder.sv
// L2 memory-port responder: serializes line/uncached requests into
// single-word beats and assembles refill lines for the L2 cache.
module l2_mem_responder #(
  parameter int OFFSET_WIDTH = 3,
  localparam int NW = 1 << OFFSET_WIDTH,
  localparam int LW = 32 * NW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   addr_l2cache_mem_r,
  input  logic [31:0]   addr_l2cache_mem_w,
  input  logic [LW-1:0] dout_l2cache_mem,
  input  logic          l2cache_mem_req_r,
  input  logic          l2cache_mem_req_w,
  input  logic          l2cache_mem_rdy,
  input  logic          l2cache_mem_SUC,
  input  logic [3:0]    l2cache_mem_wstrb,
  input  logic [1:0]    l2cache_mem_size,
  output logic          mem_l2cache_addrOK_r,
  output logic          mem_l2cache_addrOK_w,
  output logic          mem_l2cache_dataOK,
  output logic [LW-1:0] din_mem_l2cache,
  output logic          bus_req,
  output logic          bus_we,
  output logic [31:0]   bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_wstrb,
  output logic [1:0]    bus_size,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD_BEAT,
    RD_RESP,
    WR_BEAT
  } state_t;

  localparam logic [31:0] LMASK = 32'(NW * 4 - 1);

  state_t state;
  state_t state_nx;

  logic [31:0]             addr_q;
  logic                    suc_q;
  logic [1:0]              size_q;
  logic [3:0]              wstrb_q;
  logic [LW-1:0]           wline_q;
  logic [LW-1:0]           rline_q;
  logic [OFFSET_WIDTH-1:0] beat_cnt;

  logic        acc_w;
  logic        acc_r;
  logic        busy;
  logic        wr;
  logic        last;
  logic [31:0] beat_addr;
  logic [31:0] beat_off;

  // rstn gating keeps the accept strobes low during reset
  assign acc_w = rstn & (state == IDLE) & l2cache_mem_req_w;
  assign acc_r = rstn & (state == IDLE) & l2cache_mem_req_r
               & ~l2cache_mem_req_w;
  assign busy  = (state == RD_BEAT) | (state == WR_BEAT);
  assign wr    = (state == WR_BEAT);
  assign last  = suc_q | (&beat_cnt);

  assign beat_off  = 32'({beat_cnt, 2'b00});
  assign beat_addr = suc_q ? (addr_q & ~32'd3)
                           : ((addr_q & ~LMASK) | beat_off);

  assign mem_l2cache_addrOK_w = acc_w;
  assign mem_l2cache_addrOK_r = acc_r;
  assign mem_l2cache_dataOK   = (state == RD_RESP);
  assign din_mem_l2cache      = rline_q;

  assign bus_req   = busy;
  assign bus_we    = wr;
  assign bus_addr  = busy ? beat_addr : '0;
  assign bus_wdata = wr ? wline_q[{beat_cnt, 5'b0} +: 32] : '0;
  assign bus_wstrb = wr ? (suc_q ? wstrb_q : 4'hF) : '0;
  assign bus_size  = busy ? (suc_q ? size_q : 2'b10) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc_w)      state_nx = WR_BEAT;
        else if (acc_r) state_nx = RD_BEAT;
      end
      RD_BEAT: if (bus_ack && last) state_nx = RD_RESP;
      WR_BEAT: if (bus_ack && last) state_nx = IDLE;
      RD_RESP: if (l2cache_mem_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      suc_q    <= 1'b0;
      size_q   <= '0;
      wstrb_q  <= '0;
      wline_q  <= '0;
      rline_q  <= '0;
      beat_cnt <= '0;
    end else if (acc_w || acc_r) begin
      addr_q   <= acc_w ? addr_l2cache_mem_w : addr_l2cache_mem_r;
      suc_q    <= l2cache_mem_SUC;
      size_q   <= l2cache_mem_size;
      wstrb_q  <= l2cache_mem_wstrb;
      beat_cnt <= '0;
      if (acc_w) wline_q <= dout_l2cache_mem;
      // cleared so an uncached read returns zeros above word 0
      else       rline_q <= '0;
    end else if (busy && bus_ack) begin
      if (!wr) rline_q[{beat_cnt, 5'b0} +: 32] <= bus_rdata;
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder: random bus waits and data,
// checked against a line/beat model computed from addresses.
module tb_l2_mem_responder;

  localparam int NW = 8;
  localparam int LW = 32 * NW;

  logic          clk = 0;
  logic          rstn;
  logic [31:0]   addr_l2cache_mem_r;
  logic [31:0]   addr_l2cache_mem_w;
  logic [LW-1:0] dout_l2cache_mem;
  logic          l2cache_mem_req_r;
  logic          l2cache_mem_req_w;
  logic          l2cache_mem_rdy;
  logic          l2cache_mem_SUC;
  logic [3:0]    l2cache_mem_wstrb;
  logic [1:0]    l2cache_mem_size;
  logic          mem_l2cache_addrOK_r;
  logic          mem_l2cache_addrOK_w;
  logic          mem_l2cache_dataOK;
  logic [LW-1:0] din_mem_l2cache;
  logic          bus_req;
  logic          bus_we;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_wstrb;
  logic [1:0]    bus_size;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  l2_mem_responder dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .addr_l2cache_mem_r   (addr_l2cache_mem_r),
    .addr_l2cache_mem_w   (addr_l2cache_mem_w),
    .dout_l2cache_mem     (dout_l2cache_mem),
    .l2cache_mem_req_r    (l2cache_mem_req_r),
    .l2cache_mem_req_w    (l2cache_mem_req_w),
    .l2cache_mem_rdy      (l2cache_mem_rdy),
    .l2cache_mem_SUC      (l2cache_mem_SUC),
    .l2cache_mem_wstrb    (l2cache_mem_wstrb),
    .l2cache_mem_size     (l2cache_mem_size),
    .mem_l2cache_addrOK_r (mem_l2cache_addrOK_r),
    .mem_l2cache_addrOK_w (mem_l2cache_addrOK_w),
    .mem_l2cache_dataOK   (mem_l2cache_dataOK),
    .din_mem_l2cache      (din_mem_l2cache),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_wdata            (bus_wdata),
    .bus_wstrb            (bus_wstrb),
    .bus_size             (bus_size),
    .bus_ack              (bus_ack),
    .bus_rdata            (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
  } beat_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            max_wait = 0;
  int            waitc = 0;
  int            dok_cnt = 0;
  logic [31:0]   rd_xor = 0;
  beat_t         beat_q[$];
  int            acc_r_q[$];
  int            acc_w_q[$];
  int            resp_cyc[$];
  logic [LW-1:0] resp_din[$];

  // memory model: read data is the beat address xor a per-test key
  always @(negedge clk) begin
    if (!bus_req) begin
      bus_ack = 0;
      waitc = int'($urandom_range(0, max_wait));
    end else if (waitc == 0) begin
      bus_ack = 1;
      bus_rdata = bus_addr ^ rd_xor;
      waitc = int'($urandom_range(0, max_wait));
    end else begin
      bus_ack = 0;
      waitc--;
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (mem_l2cache_addrOK_r) acc_r_q.push_back(cyc);
      if (mem_l2cache_addrOK_w) acc_w_q.push_back(cyc);
      if (bus_req && bus_ack)
        beat_q.push_back('{cyc, bus_we, bus_addr, bus_wdata,
                           bus_wstrb, bus_size});
      if (mem_l2cache_dataOK) begin
        dok_cnt++;
        if (l2cache_mem_rdy) begin
          resp_cyc.push_back(cyc);
          resp_din.push_back(din_mem_l2cache);
        end
      end
    end
    cyc++;
  end

  function automatic logic [LW-1:0] exp_line(input logic [31:0] a,
                                             input bit suc,
                                             input logic [31:0] x);
    logic [LW-1:0] l;
    l = '0;
    if (suc) l[31:0] = (a & ~32'd3) ^ x;
    else
      for (int i = 0; i < NW; i++)
        l[32*i +: 32] = ((a & ~32'h1F) + 32'(4 * i)) ^ x;
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < NW; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic clear_logs();
    beat_q.delete();
    acc_r_q.delete();
    acc_w_q.delete();
    resp_cyc.delete();
    resp_din.delete();
    dok_cnt = 0;
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input bit suc,
                       input logic [LW-1:0] d, input logic [3:0] st,
                       input logic [1:0] sz, output bit ok);
    ok = 0;
    @(negedge clk);
    l2cache_mem_SUC = suc;
    l2cache_mem_wstrb = st;
    l2cache_mem_size = sz;
    if (wr) begin
      addr_l2cache_mem_w = a;
      dout_l2cache_mem = d;
      l2cache_mem_req_w = 1;
    end else begin
      addr_l2cache_mem_r = a;
      l2cache_mem_req_r = 1;
    end
    for (int k = 0; k < 200; k++) begin
      #1;
      if (wr ? mem_l2cache_addrOK_w : mem_l2cache_addrOK_r) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    l2cache_mem_req_w = 0;
    l2cache_mem_req_r = 0;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (resp_cyc.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    l2cache_mem_req_r = 1;
    l2cache_mem_req_w = 1;
    #1;
    checks++;
    if ({mem_l2cache_addrOK_r, mem_l2cache_addrOK_w} !== 2'b00) begin
      failures++;
      $display("FAIL rst_addrok got=%b want=00",
               {mem_l2cache_addrOK_r, mem_l2cache_addrOK_w});
    end
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size}
        !== '0) begin
      failures++;
      $display("FAIL rst_bus req=%b addr=%h wdata=%h strb=%h size=%b",
               bus_req, bus_addr, bus_wdata, bus_wstrb, bus_size);
    end
    checks++;
    if (mem_l2cache_dataOK !== 0 || din_mem_l2cache !== '0) begin
      failures++;
      $display("FAIL rst_resp dataOK=%b din=%h want 0",
               mem_l2cache_dataOK, din_mem_l2cache);
    end
    @(negedge clk);
    l2cache_mem_req_r = 0;
    l2cache_mem_req_w = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_cached_read();
    bit ok, ok2;
    int n;
    clear_logs();
    max_wait = 0;
    rd_xor = 0;
    l2cache_mem_rdy = 1;
    issue(0, 32'h0000_1234, 0, '0, 4'h0, 2'b00, ok);
    wait_resp(1, ok2);
    checks++;
    if (!ok || !ok2 || acc_r_q.size() != 1 || beat_q.size() != 8) begin
      failures++;
      $display("FAIL cr_flow ok=%0d/%0d acc=%0d beats=%0d want 1/1 1 8",
               ok, ok2, acc_r_q.size(), beat_q.size());
    end else begin
      n = acc_r_q[0];
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beat_q[i].addr !== 32'h1220 + 32'(4 * i) || beat_q[i].we
            || beat_q[i].size !== 2'b10 || beat_q[i].cyc != n + 1 + i) begin
          failures++;
          $display("FAIL cr_beat%0d addr=%h we=%b size=%b cyc=%0d want %h 0 10 %0d",
                   i, beat_q[i].addr, beat_q[i].we, beat_q[i].size,
                   beat_q[i].cyc, 32'h1220 + 32'(4 * i), n + 1 + i);
        end
      end
      checks++;
      if (resp_cyc[0] != n + 9) begin
        failures++;
        $display("FAIL cr_latency got=%0d want=%0d", resp_cyc[0], n + 9);
      end
      checks++;
      if (resp_din[0] !== exp_line(32'h1234, 0, 0)) begin
        failures++;
        $display("FAIL cr_line got=%h want=%h", resp_din[0],
                 exp_line(32'h1234, 0, 0));
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [LW-1:0] wd;
    clear_logs();
    max_wait = 0;
    rd_xor = $urandom;
    wd = rand_line();
    @(negedge clk);
    addr_l2cache_mem_w = 32'h3000;
    addr_l2cache_mem_r = 32'h2000;
    dout_l2cache_mem = wd;
    l2cache_mem_SUC = 0;
    l2cache_mem_req_r = 1;
    l2cache_mem_req_w = 1;
    #1;
    checks++;
    if (mem_l2cache_addrOK_w !== 1 || mem_l2cache_addrOK_r !== 0) begin
      failures++;
      $display("FAIL sim_prio okw=%b okr=%b want 1 0",
               mem_l2cache_addrOK_w, mem_l2cache_addrOK_r);
    end
    @(negedge clk);
    l2cache_mem_req_w = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (mem_l2cache_addrOK_r) break;
      @(negedge clk);
    end
    @(negedge clk);
    l2cache_mem_req_r = 0;
    wait_resp(1, ok);
    checks++;
    if (!ok || beat_q.size() != 16 || acc_w_q.size() != 1
        || acc_r_q.size() != 1) begin
      failures++;
      $display("FAIL sim_flow ok=%0d beats=%0d accw=%0d accr=%0d want 1 16 1 1",
               ok, beat_q.size(), acc_w_q.size(), acc_r_q.size());
    end else begin
      checks++;
      if (acc_r_q[0] != acc_w_q[0] + 9) begin
        failures++;
        $display("FAIL sim_order accr=%0d want=%0d", acc_r_q[0],
                 acc_w_q[0] + 9);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (!beat_q[i].we || beat_q[i].addr !== 32'h3000 + 32'(4 * i)
            || beat_q[i].wdata !== wd[32*i +: 32]
            || beat_q[i].strb !== 4'hF) begin
          failures++;
          $display("FAIL sim_wbeat%0d we=%b addr=%h data=%h strb=%h want 1 %h %h F",
                   i, beat_q[i].we, beat_q[i].addr, beat_q[i].wdata,
                   beat_q[i].strb, 32'h3000 + 32'(4 * i), wd[32*i +: 32]);
        end
        checks++;
        if (beat_q[i+8].we || beat_q[i+8].addr !== 32'h2000 + 32'(4 * i)) begin
          failures++;
          $display("FAIL sim_rbeat%0d we=%b addr=%h want 0 %h", i,
                   beat_q[i+8].we, beat_q[i+8].addr, 32'h2000 + 32'(4 * i));
        end
      end
      checks++;
      if (resp_din[0] !== exp_line(32'h2000, 0, rd_xor)) begin
        failures++;
        $display("FAIL sim_line got=%h want=%h", resp_din[0],
                 exp_line(32'h2000, 0, rd_xor));
      end
    end
  endtask

  task automatic test_suc_write();
    bit ok;
    logic [LW-1:0] wd;
    clear_logs();
    max_wait = 0;
    wd = rand_line();
    issue(1, 32'h8000_0006, 1, wd, 4'b1100, 2'b01, ok);
    repeat (8) @(negedge clk);
    checks++;
    if (!ok || beat_q.size() != 1 || acc_w_q.size() != 1) begin
      failures++;
      $display("FAIL sw_flow ok=%0d beats=%0d want 1 1", ok, beat_q.size());
    end else begin
      checks++;
      if (!beat_q[0].we || beat_q[0].addr !== 32'h8000_0004
          || beat_q[0].strb !== 4'b1100 || beat_q[0].size !== 2'b01
          || beat_q[0].wdata !== wd[31:0]
          || beat_q[0].cyc != acc_w_q[0] + 1) begin
        failures++;
        $display("FAIL sw_beat we=%b addr=%h strb=%b size=%b data=%h want 1 80000004 1100 01 %h",
                 beat_q[0].we, beat_q[0].addr, beat_q[0].strb,
                 beat_q[0].size, beat_q[0].wdata, wd[31:0]);
      end
    end
    checks++;
    if (dok_cnt != 0) begin
      failures++;
      $display("FAIL sw_nodataok got=%0d want=0", dok_cnt);
    end
  endtask

  task automatic test_suc_read();
    bit ok, ok2;
    logic [31:0] a;
    clear_logs();
    max_wait = 0;
    rd_xor = $urandom;
    a = $urandom;
    issue(0, a, 1, '0, 4'h0, 2'b00, ok);
    wait_resp(1, ok2);
    checks++;
    if (!ok || !ok2 || beat_q.size() != 1 || acc_r_q.size() != 1) begin
      failures++;
      $display("FAIL sr_flow ok=%0d/%0d beats=%0d want 1/1 1",
               ok, ok2, beat_q.size());
    end else begin
      checks++;
      if (beat_q[0].addr !== (a & ~32'd3) || beat_q[0].size !== 2'b00
          || resp_cyc[0] != acc_r_q[0] + 2) begin
        failures++;
        $display("FAIL sr_beat addr=%h size=%b cyc=%0d want %h 00 %0d",
                 beat_q[0].addr, beat_q[0].size, resp_cyc[0],
                 a & ~32'd3, acc_r_q[0] + 2);
      end
      checks++;
      if (resp_din[0] !== exp_line(a, 1, rd_xor)) begin
        failures++;
        $display("FAIL sr_line got=%h want=%h", resp_din[0],
                 exp_line(a, 1, rd_xor));
      end
    end
  endtask

  task automatic test_rdy_stall();
    bit ok;
    bit seen;
    logic [31:0] a;
    logic [LW-1:0] want;
    clear_logs();
    max_wait = 1;
    rd_xor = $urandom;
    a = $urandom;
    want = exp_line(a, 0, rd_xor);
    l2cache_mem_rdy = 0;
    issue(0, a, 0, '0, 4'h0, 2'b00, ok);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (mem_l2cache_dataOK) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!ok || !seen) begin
      failures++;
      $display("FAIL rs_timeout ok=%0d seen=%0d", ok, seen);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem_l2cache_dataOK !== 1 || din_mem_l2cache !== want) begin
        failures++;
        $display("FAIL rs_hold%0d dataOK=%b din=%h want 1 %h", i,
                 mem_l2cache_dataOK, din_mem_l2cache, want);
      end
      if (i == 5) l2cache_mem_rdy = 1;
      @(negedge clk);
      #1;
    end
    checks++;
    if (mem_l2cache_dataOK !== 0 || bus_req !== 0 || dok_cnt != 6
        || resp_cyc.size() != 1) begin
      failures++;
      $display("FAIL rs_release dataOK=%b req=%b cnt=%0d resp=%0d want 0 0 6 1",
               mem_l2cache_dataOK, bus_req, dok_cnt, resp_cyc.size());
    end
  endtask

  task automatic test_random_waits();
    bit ok;
    bit wr;
    bit hold;
    bit done;
    logic [31:0] a, sa, sd;
    logic [LW-1:0] wd;
    max_wait = 3;
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      wr = (it % 2) == 0;
      a = $urandom;
      wd = rand_line();
      rd_xor = $urandom;
      issue(wr, a, 0, wd, 4'h0, 2'b00, ok);
      hold = 0;
      done = 0;
      sa = 0;
      sd = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        #1;
        if (hold && bus_req) begin
          checks++;
          if (bus_addr !== sa || bus_wdata !== sd) begin
            failures++;
            $display("FAIL rw_stable it%0d addr=%h data=%h want %h %h",
                     it, bus_addr, bus_wdata, sa, sd);
          end
        end
        hold = bus_req && !bus_ack;
        sa = bus_addr;
        sd = bus_wdata;
        done = wr ? (beat_q.size() == 8 && !bus_req)
                  : (resp_cyc.size() == 1);
        if (done) break;
      end
      checks++;
      if (!ok || !done || beat_q.size() != 8) begin
        failures++;
        $display("FAIL rw_flow it%0d ok=%0d done=%0d beats=%0d want 1 1 8",
                 it, ok, done, beat_q.size());
      end else if (wr) begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (beat_q[i].addr !== (a & ~32'h1F) + 32'(4 * i)
              || beat_q[i].wdata !== wd[32*i +: 32]) begin
            failures++;
            $display("FAIL rw_wbeat it%0d.%0d addr=%h data=%h want %h %h",
                     it, i, beat_q[i].addr, beat_q[i].wdata,
                     (a & ~32'h1F) + 32'(4 * i), wd[32*i +: 32]);
          end
        end
      end else begin
        checks++;
        if (resp_din[0] !== exp_line(a, 0, rd_xor)) begin
          failures++;
          $display("FAIL rw_line it%0d got=%h want=%h", it, resp_din[0],
                   exp_line(a, 0, rd_xor));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok, ok2;
    logic [31:0] a;
    clear_logs();
    max_wait = 0;
    rd_xor = $urandom;
    issue(0, $urandom, 0, '0, 4'h0, 2'b00, ok);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (beat_q.size() >= 3) break;
    end
    rstn = 0;
    l2cache_mem_req_r = 1;
    #1;
    checks++;
    if ({mem_l2cache_addrOK_r, mem_l2cache_dataOK, bus_req, bus_addr,
         bus_size} !== '0 || din_mem_l2cache !== '0 || beat_q.size() != 3) begin
      failures++;
      $display("FAIL rm_zero okr=%b dok=%b req=%b addr=%h din=%h beats=%0d",
               mem_l2cache_addrOK_r, mem_l2cache_dataOK, bus_req, bus_addr,
               din_mem_l2cache, beat_q.size());
    end
    @(negedge clk);
    l2cache_mem_req_r = 0;
    @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (dok_cnt != 0 || resp_cyc.size() != 0) begin
      failures++;
      $display("FAIL rm_stale dataOK count=%0d want=0", dok_cnt);
    end
    clear_logs();
    rd_xor = $urandom;
    a = $urandom;
    issue(0, a, 0, '0, 4'h0, 2'b00, ok);
    wait_resp(1, ok2);
    checks++;
    if (!ok || !ok2 || resp_din.size() != 1
        || resp_din[0] !== exp_line(a, 0, rd_xor)) begin
      failures++;
      $display("FAIL rm_after ok=%0d/%0d resp=%0d want line %h",
               ok, ok2, resp_din.size(), exp_line(a, 0, rd_xor));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 0;
    addr_l2cache_mem_r = 0;
    addr_l2cache_mem_w = 0;
    dout_l2cache_mem = '0;
    l2cache_mem_req_r = 0;
    l2cache_mem_req_w = 0;
    l2cache_mem_rdy = 1;
    l2cache_mem_SUC = 0;
    l2cache_mem_wstrb = 0;
    l2cache_mem_size = 0;
    bus_ack = 0;
    bus_rdata = 0;
    test_reset();
    test_cached_read();
    test_simultaneous();
    test_suc_write();
    test_suc_read();
    test_rdy_stall();
    test_random_waits();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Memory-side responder for the L2 cache's memory port. It accepts line read/write requests and uncached single-word requests from the L2 cache, serializes them into single-word beats on a simple word bus toward main memory, and returns assembled refill lines to the L2 cache. It handles one transaction at a time and sits between the L2 cache and the SoC memory bus.

## Interface
- OFFSET_WIDTH, 3, log2 of words per L2 line; line width LW = 32*(1<<OFFSET_WIDTH).

- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- addr_l2cache_mem_r  in  32  read address.
- addr_l2cache_mem_w  in  32  write address.
- dout_l2cache_mem  in  LW  write line data; word i in bits [32i+31:32i].
- l2cache_mem_req_r  in  1  read request, held until addrOK_r.
- l2cache_mem_req_w  in  1  write request, held until addrOK_w.
- l2cache_mem_rdy  in  1  L2 cache can take read data this cycle.
- l2cache_mem_SUC  in  1  1 = uncached single-word access; 0 = cached full line.
- l2cache_mem_wstrb  in  4  byte strobes for SUC writes.
- l2cache_mem_size  in  2  access size for SUC accesses, forwarded to the bus.
- mem_l2cache_addrOK_r  out  1  read request accepted (1-cycle pulse).
- mem_l2cache_addrOK_w  out  1  write request accepted (1-cycle pulse).
- mem_l2cache_dataOK  out  1  read data valid on din_mem_l2cache.
- din_mem_l2cache  out  LW  read line data.
- bus_req  out  1  word-bus beat request.
- bus_we  out  1  1 = write beat.
- bus_addr  out  32  word-bus address, word-aligned ([1:0] = 0).
- bus_wdata  out  32  write beat data.
- bus_wstrb  out  4  write beat strobes.
- bus_size  out  2  beat size (2'b10 for cached beats).
- bus_ack  in  1  beat completed; bus_rdata valid on read beats.
- bus_rdata  in  32  read beat data.

## Operation
- States: IDLE, RD_BEAT, RD_RESP, WR_BEAT.
- IDLE:
  - addrOK_w = req_w.
  - addrOK_r = req_r & ~req_w.
  - Both outputs are combinational and asserted only in IDLE. Write wins a simultaneous request, so victim writeback precedes refill.
- On accept:
  - Latch address, SUC, size and wstrb. For writes, also latch the line data.
  - beat_cnt = 0.
  - Move to WR_BEAT or RD_BEAT.
- Beat count:
  - SUC = 0: 1<<OFFSET_WIDTH beats.
  - SUC = 1: exactly one beat.
- Beat address:
  - SUC = 0: {addr[31:OFFSET_WIDTH+2], beat_cnt, 2'b00}. Beats are issued in ascending word order, always starting from the line base regardless of the request's low address bits.
  - SUC = 1: {addr[31:2], 2'b00}.
- Write beats:
  - bus_wdata = latched word [beat_cnt].
  - bus_wstrb = 4'hF if SUC = 0, else the latched wstrb.
- Read beats:
  - On bus_ack, bus_rdata is stored into word [beat_cnt] of the line buffer.
  - SUC = 1: the word is stored into word 0 and all other words are zero.
- bus_req stays high in RD_BEAT/WR_BEAT. Each bus_ack advances beat_cnt (wraps at the line size). bus_addr and bus_wdata update the cycle after the ack.
- On the last ack:
  - WR_BEAT goes to IDLE. Writes are posted: no dataOK for writes.
  - RD_BEAT goes to RD_RESP.
- RD_RESP:
  - dataOK = 1 and din_mem_l2cache holds the buffer, stable until rdy = 1 is sampled.
  - On dataOK & rdy, go to IDLE. A new request can be accepted in the following cycle.
- A request that stays asserted through a busy state is accepted on the first IDLE cycle.
- bus_size = 2'b10 for cached beats; for SUC beats it is the latched size.

## Timing
- Reset (async, rstn = 0):
  - State goes to IDLE; beat_cnt and the buffers clear.
  - Outputs: all bus_* = 0, dataOK = 0, din = 0; addrOK_r/addrOK_w = 0 while rstn = 0.
  - A reset during an active transaction abandons it; no partial dataOK.
- Read latency, cached, zero-wait bus (ack in the same cycle as req):
  - Accept at cycle N.
  - bus_req high at N+1 … N+8.
  - dataOK at N+9 if rdy = 1.
- Each wait cycle on bus_ack adds one cycle. Each rdy = 0 cycle extends RD_RESP by one cycle.
- SUC read: accept at N, beat at N+1, dataOK at N+2 (zero-wait bus).
- Cached write: accept at N, beats at N+1 … N+8, back in IDLE at N+9.

## Test plan
- Cached read, addr_r = 0x0000_1234, bus_rdata = beat address, bus_ack tied high:
  - addrOK_r at N.
  - bus_addr = 0x1220, 0x1224, … 0x123C.
  - dataOK at N+9 with word i = 0x1220 + 4i.
- Simultaneous req_r (0x2000) and req_w (0x3000) in IDLE:
  - addrOK_w pulses first.
  - 8 write beats go to 0x3000–0x301C with wstrb F.
  - Then addrOK_r, then the read beats at 0x2000.
- SUC write, addr 0x8000_0006, wstrb 4'b1100, size 2'b01:
  - Exactly one beat: bus_addr 0x8000_0004, wstrb 4'b1100, bus_size 01.
  - No dataOK.
- Cached read with rdy low for 5 cycles after the data is ready:
  - dataOK held high 6 cycles with din stable.
  - Returns to IDLE after the rdy = 1 cycle.
- bus_ack with random waits (0–3 cycles):
  - bus_addr and bus_wdata stay stable while bus_req is high without ack.
  - Line contents are correct.
- rstn asserted mid-read after 3 beats:
  - All outputs 0 immediately.
  - After release, a new read completes correctly with no stale dataOK.
